// File: rtl/ffe_pkg.sv
// ffe_equalizer shared defaults, coefficient types and fixed-point helpers.
// Optional FFE_COEF_SHADOW_EN build is handled in ffe_if / ffe_coef_bank.
package ffe_pkg;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_COEF_W   = 8;
   localparam int DEF_FRAC_W   = 6;
   localparam int DEF_NTAPS    = 5;
   localparam int DEF_MAIN_IDX = 1;
   localparam int DEF_OUT_W    = 10;

   localparam int COEF_ONE = 1 << DEF_FRAC_W;

   typedef logic signed [DEF_COEF_W-1:0] coef_t;
   typedef coef_t coef_bank_t [DEF_NTAPS];

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

   // Round half toward +inf, then clamp to a signed out_w range.
   function automatic logic signed [31:0] sat_round(
      input  logic signed [63:0] acc,
      input  int                 frac_w,
      input  int                 out_w,
      output logic               clip
   );
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r    = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
      hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo   = -(64'sd1 <<< (out_w - 1));
      clip = 1'b0;
      if (r > hi) begin
         r    = hi;
         clip = 1'b1;
      end else if (r < lo) begin
         r    = lo;
         clip = 1'b1;
      end
      return 32'(r);
   endfunction
endpackage

// File: rtl/ffe_if.sv
// Sample, coefficient-write and output bundle of ffe_equalizer.
// FFE_COEF_SHADOW_EN adds the coef_commit strobe.
interface ffe_if import ffe_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int AW     = clog2(DEF_NTAPS)
) ();
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     coef_we;
   logic [AW-1:0]            coef_addr;
   logic signed [COEF_W-1:0] coef_data;
`ifdef FFE_COEF_SHADOW_EN
   logic                     coef_commit;
`endif
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_sat;

   modport master (
`ifdef FFE_COEF_SHADOW_EN
      output coef_commit,
`endif
      output in_valid, in_data, coef_we, coef_addr, coef_data,
      input  out_valid, out_data, out_sat
   );

   modport slave (
`ifdef FFE_COEF_SHADOW_EN
      input  coef_commit,
`endif
      input  in_valid, in_data, coef_we, coef_addr, coef_data,
      output out_valid, out_data, out_sat
   );
endinterface

// File: rtl/ffe_coef_bank.sv
// FFE tap coefficient file with identity reset and range-checked writes.
// FFE_COEF_SHADOW_EN: writes land in a shadow bank, coef_commit copies it.
module ffe_coef_bank import ffe_pkg::*; #(
   parameter int NTAPS    = DEF_NTAPS,
   parameter int COEF_W   = DEF_COEF_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int MAIN_IDX = DEF_MAIN_IDX,
   parameter int AW       = clog2(DEF_NTAPS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [AW-1:0]                addr,
   input  logic [COEF_W-1:0]            wdata,
`ifdef FFE_COEF_SHADOW_EN
   input  logic                         commit,
`endif
   output logic [NTAPS-1:0][COEF_W-1:0] coef
);
   typedef logic [NTAPS-1:0][COEF_W-1:0] bank_t;

   function automatic bank_t ident();
      bank_t b;
      b           = '0;
      b[MAIN_IDX] = COEF_W'(1 << FRAC_W);
      return b;
   endfunction

   localparam bank_t IDENT = ident();

   logic  addr_ok;
   bank_t src;
   bank_t nxt;

   assign addr_ok = {1'b0, addr} < (AW+1)'(NTAPS);

   always_comb begin
      nxt = src;
      if (we && addr_ok) nxt[addr] = wdata;
   end

`ifdef FFE_COEF_SHADOW_EN
   bank_t shd;

   assign src = shd;

   // Commit takes nxt so a same-cycle write is part of the swap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shd  <= IDENT;
         coef <= IDENT;
      end else begin
         shd <= nxt;
         if (commit) coef <= nxt;
      end
   end
`else
   assign src = coef;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) coef <= IDENT;
      else     coef <= nxt;
   end
`endif
endmodule

// File: rtl/ffe_equalizer.sv
// Multi-tap FFE: delay line, registered products, round/saturate stage.
// Optional build macro FFE_COEF_SHADOW_EN enables shadow coefficients.
module ffe_equalizer import ffe_pkg::*; #(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int COEF_W   = DEF_COEF_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int NTAPS    = DEF_NTAPS,
   parameter int MAIN_IDX = DEF_MAIN_IDX,
   parameter int OUT_W    = DEF_OUT_W
) (
   input logic  clk,
   input logic  rst,
   ffe_if.slave io
);
   localparam int AW    = clog2(NTAPS);
   localparam int PW    = DATA_W + COEF_W;
   localparam int ACC_W = PW + AW;

   if (MAIN_IDX >= NTAPS) begin : g_bad_main
      $error("ffe_equalizer: MAIN_IDX must be below NTAPS");
   end

   logic [NTAPS-1:0][COEF_W-1:0] coef;
   logic signed [DATA_W-1:0]     dl [NTAPS-1];
   logic signed [DATA_W-1:0]     dp [NTAPS];
   logic signed [PW-1:0]         prod [NTAPS];
   logic signed [ACC_W-1:0]      acc;
   logic [OUT_W-1:0]             y;
   logic                         y_clip;
   logic                         v1;

   ffe_coef_bank #(
      .NTAPS(NTAPS), .COEF_W(COEF_W), .FRAC_W(FRAC_W),
      .MAIN_IDX(MAIN_IDX), .AW(AW)
   ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (io.coef_we),
      .addr  (io.coef_addr),
      .wdata (io.coef_data),
`ifdef FFE_COEF_SHADOW_EN
      .commit(io.coef_commit),
`endif
      .coef  (coef)
   );

   always_comb begin
      dp[0] = io.in_data;
      for (int k = 1; k < NTAPS; k++) dp[k] = dl[k-1];
   end

   // coef still holds pre-edge values, so a colliding write lands one sample later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NTAPS-1; k++) dl[k] <= '0;
         for (int k = 0; k < NTAPS; k++) prod[k] <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= io.in_valid;
         if (io.in_valid) begin
            for (int k = 0; k < NTAPS-1; k++) dl[k] <= dp[k];
            for (int k = 0; k < NTAPS; k++)
               prod[k] <= PW'($signed(coef[k])) * PW'(dp[k]);
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int k = 0; k < NTAPS; k++) acc = acc + ACC_W'(prod[k]);
   end

   always_comb begin
      y_clip = 1'b0;
      y      = OUT_W'(sat_round(64'(acc), FRAC_W, OUT_W, y_clip));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io.out_valid <= 1'b0;
         io.out_data  <= '0;
         io.out_sat   <= 1'b0;
      end else begin
         io.out_valid <= v1;
         if (v1) begin
            io.out_data <= y;
            io.out_sat  <= y_clip;
         end
      end
   end
endmodule

// File: doc/ffe_equalizer.md
Name: ffe_equalizer

Overview:
- Clocked, fixed-point, multi-tap feed-forward equalizer (FFE) for the receive path. It sits between the channel model/ADC sample stream and the slicer/CDR.
- Generalises the single-zero real-valued equalizer. It adds NTAPS programmable signed coefficients, a valid handshake, a two-stage pipelined multiply-accumulate, rounding, saturation, and a runtime coefficient write port.

Parameters:
- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- FRAC_W, 6, coefficient fractional bits (1.0 = 1<<FRAC_W = 64)
- NTAPS, 5, number of taps (>=2)
- MAIN_IDX, 1, cursor tap index; taps below it are pre-cursor, taps above it are post-cursor
- OUT_W, 10, signed output width

Ports:
- clk  in  1  sample clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  in_data qualifier
- in_data  in  DATA_W  signed sample x[n]
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index
- coef_data  in  COEF_W  signed coefficient value
- out_valid  out  1  out_data qualifier
- out_data  out  OUT_W  signed equalized sample y[n]
- out_sat  out  1  y[n] was clipped; qualified by out_valid

Behaviour:
- Reset: delay line is all zero. c[MAIN_IDX] = 1<<FRAC_W and all other c[k] = 0 (identity). out_valid=0, out_data=0, out_sat=0. Any in-flight samples are discarded. A mid-operation reset takes effect immediately and asynchronously; the first out_valid after reset release needs a fresh in_valid.
- Delay line: d[0..NTAPS-1] shifts only on cycles with in_valid=1. On those cycles d[0]<=in_data and d[k]<=d[k-1]. When in_valid=0 the line holds.
- Filter: y = sum over k of c[k]*d'[k], where d' is the delay-line contents including the sample just accepted (d'[0]=x[n], d'[k]=x[n-k]).
- Stage 1, on the in_valid edge: register the NTAPS products, each DATA_W+COEF_W signed, using the coefficients current at that edge.
- Stage 2: sum with ACC_W = DATA_W+COEF_W+clog2(NTAPS) signed, so there is no internal overflow.
  - Add 1<<(FRAC_W-1) and arithmetic-shift right by FRAC_W (round half toward +inf).
  - Saturate to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]; out_sat=1 when clipped.
- Latency: out_valid follows in_valid by exactly 2 clk cycles.
  - Gaps in in_valid propagate as gaps in out_valid.
  - out_data and out_sat hold their last value when out_valid=0.
  - The block accepts one sample per cycle with no backpressure.
- Coefficient write: on coef_we=1, c[coef_addr]<=coef_data at that edge.
  - coef_addr >= NTAPS is ignored.
  - If coef_we and in_valid are high in the same cycle, that sample uses the OLD coefficients. The new value applies from the next accepted sample.
- NTAPS=MAIN_IDX+1 is legal (no post-cursor taps). MAIN_IDX >= NTAPS is an elaboration error.

Optional Feature:
- Macro FFE_COEF_SHADOW_EN.
- Defined:
  - Adds input port coef_commit (1 bit).
  - coef_we writes a shadow bank; the active bank is unchanged.
  - A coef_commit pulse copies the whole shadow bank to the active bank atomically at that edge.
  - If coef_we and coef_commit are both high in one cycle, the commit includes that write.
  - Reset loads both banks with identity.
- Undefined: no coef_commit port; writes go directly to the active bank as described in Behaviour.

Decomposition:
- Package ffe_pkg:
  - function clog2
  - function sat_round(acc, FRAC_W, OUT_W) returning value and clip flag
  - localparam for identity coefficient (1<<FRAC_W)
  - typedef for the coefficient bank as a signed array
- One sub-module, ffe_coef_bank: the register file, reset-to-identity, write decode, and optional shadow/commit. The top holds the delay line, MAC pipeline and valid pipe.

Test Plan:
- Identity after reset: drive in_valid continuously with x = 10, 20, -30. out_data is 0, 10, 20, -30, starting 2 cycles after the first in_valid (x[n-1] alignment); out_sat=0.
- Pre/post-cursor: set c0=-16 (-0.25), c1=64, c2=-16. Apply a step of 0 then 40 held. Outputs are -10, 30, 20, 20...
- Rounding: only c1=32 (0.5). x=1 gives y=1 (32+32=64>>6); x=-1 gives y=0; x=-3 gives y=-1.
- Saturation: all c=127, x=127 sustained for 5 samples. Final out_data=511 with out_sat=1. With x=-128 the output is -512 with out_sat=1.
- Handshake gaps, write collision and bad address:
  - in_valid pattern 1,0,1 gives out_valid pattern 1,0,1 two cycles later, with out_data held during the gap.
  - coef_we with in_valid in the same cycle: that sample uses the old coefficients.
  - coef_addr=7 with NTAPS=5 causes no change.
- Reset mid-stream: assert rst during back-to-back samples. out_valid drops at once, the delay line reads zero, and the coefficients return to identity. With FFE_COEF_SHADOW_EN, an uncommitted shadow write has no effect on output until coef_commit.
